// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1RW/1R SRAM model.
// Holds the init-sweep state encoding and the masked word merge.
package sram_pkg;

    typedef enum logic [1:0] {
        S_RESET,
        S_INIT,
        S_RUN
    } init_state_t;

    localparam int DEF_ADDR_W  = 7;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_BYTE_W  = 8;
    localparam int DEF_SPARE_W = 1;
    localparam int DEF_NBYTES  = DEF_DATA_W / DEF_BYTE_W;
    localparam int DEF_WORD_W  = DEF_DATA_W + DEF_SPARE_W;

    // Widest word the merge helper supports; callers zero-extend into it.
    localparam int MAX_W = 1024;

    function automatic logic [MAX_W-1:0] merge_word(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_W-1:0] bit_en
    );
        return (old_w & ~bit_en) | (new_w & bit_en);
    endfunction

endpackage

// File: rtl/sram_1rw1r_param_init_fsm.sv
// Post-reset zero-fill sequencer for the SRAM array.
// Drives one clearing write per cycle until every word is swept.
module sram_init_fsm
    import sram_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int WORD_W        = DEF_WORD_W,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [WORD_W-1:0] init_data,
    output logic              init_busy
);

    init_state_t       state;
    logic [ADDR_W-1:0] cnt;

    // The RESET state already performs the address-0 write, so the whole
    // sweep fits in exactly DEPTH edges after reset release.
    assign init_we   = init_busy;
    assign init_addr = cnt;
    assign init_data = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RESET;
            cnt       <= '0;
            init_busy <= 1'(INIT_ON_RESET != 0);
        end else begin
            case (state)
                S_RESET: begin
                    if (INIT_ON_RESET != 0) begin
                        cnt   <= cnt + 1'b1;
                        state <= S_INIT;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state     <= S_RUN;
                        init_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state     <= S_RUN;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised single-clock SRAM: port 0 read/write with byte mask,
// port 1 read-only with write-first forwarding from port 0.
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int BYTE_W        = DEF_BYTE_W,
    parameter int SPARE_W       = DEF_SPARE_W,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       csb0,
    input  logic                       web0,
    input  logic [DATA_W/BYTE_W-1:0]   wmask0,
    input  logic                       spare_wen0,
    input  logic [ADDR_W-1:0]          addr0,
    input  logic [DATA_W+SPARE_W-1:0]  din0,
    output logic [DATA_W+SPARE_W-1:0]  dout0,
    output logic                       dout0_valid,
    input  logic                       csb1,
    input  logic [ADDR_W-1:0]          addr1,
    output logic [DATA_W+SPARE_W-1:0]  dout1,
    output logic                       dout1_valid,
    output logic                       collision,
    output logic                       init_busy
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int WORD_W = DATA_W + SPARE_W;

    logic [WORD_W-1:0] mem [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [WORD_W-1:0] init_data;

    logic              rd0, wr0, rd1, hit;
    logic [WORD_W-1:0] bit_en, wr_word, rd1_word;

    logic [WORD_W-1:0] d0_q, d1_q;
    logic              v0_q, v1_q, col_q;

    sram_init_fsm #(
        .ADDR_W       (ADDR_W),
        .WORD_W       (WORD_W),
        .INIT_ON_RESET(INIT_ON_RESET)
    ) u_init (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_we  (init_we),
        .init_addr(init_addr),
        .init_data(init_data),
        .init_busy(init_busy)
    );

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        assign bit_en[i*BYTE_W +: BYTE_W] = {BYTE_W{wmask0[i]}};
    end

    if (SPARE_W > 0) begin : g_spare
        assign bit_en[DATA_W +: SPARE_W] = {SPARE_W{spare_wen0}};
    end

    assign rd0 = !init_busy && !csb0 && web0;
    assign wr0 = !init_busy && !csb0 && !web0;
    assign rd1 = !init_busy && !csb1;

    assign wr_word = WORD_W'(merge_word(MAX_W'(mem[addr0]),
                                        MAX_W'(din0),
                                        MAX_W'(bit_en)));

    // An all-disabled write changes nothing, so it is not a collision.
    assign hit      = wr0 && rd1 && (addr0 == addr1) && (|bit_en);
    assign rd1_word = hit ? wr_word : mem[addr1];

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end else if (wr0) begin
            mem[addr0] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_q  <= '0;
            d1_q  <= '0;
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            col_q <= 1'b0;
        end else begin
            v0_q  <= rd0;
            v1_q  <= rd1;
            col_q <= hit;
            if (rd0) d0_q <= mem[addr0];
            if (rd1) d1_q <= rd1_word;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout0       <= '0;
                dout1       <= '0;
                dout0_valid <= 1'b0;
                dout1_valid <= 1'b0;
                collision   <= 1'b0;
            end else begin
                dout0       <= d0_q;
                dout1       <= d1_q;
                dout0_valid <= v0_q;
                dout1_valid <= v1_q;
                collision   <= col_q;
            end
        end
    end else begin : g_noreg
        assign dout0       = d0_q;
        assign dout1       = d1_q;
        assign dout0_valid = v0_q;
        assign dout1_valid = v1_q;
        assign collision   = col_q;
    end

endmodule
